pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline.
//  - Detects RAW hazards between the ID instruction and the EXE/MEM destinations.
//  - Tracks multi-cycle SRAM accesses with an FSM and a wait timer.
//  - Drives the freeze, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers.
//  - Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipeline_hazard_ctrl                                            |
// | Brief    : Stall/flush sequencer for a 5-stage pipeline: RAW hazard        |
// |            detection, SRAM wait tracking with timeout, stall counter.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fw_en,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_two_src,
  input  logic [4:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             freeze_id_ex,
  output logic             freeze_ex_mem,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [7:0]       c_wait_max = 8'(WAIT_MAX);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } state_t;

  state_t           r_state;
  logic [7:0]       r_timer;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_count;

  logic w_exe_hit, w_mem_hit, w_hazard;
  logic w_freeze_all, w_flush, w_stall;

  // Register r0 is hard-wired zero, so it never creates a dependency.
  always_comb begin
    w_exe_hit = ((id_src1 != 5'd0) && exe_wb_en && (id_src1 == exe_dest)) ||
                (id_two_src && (id_src2 != 5'd0) && exe_wb_en && (id_src2 == exe_dest));
    w_mem_hit = ((id_src1 != 5'd0) && mem_wb_en && (id_src1 == mem_dest)) ||
                (id_two_src && (id_src2 != 5'd0) && mem_wb_en && (id_src2 == mem_dest));
    w_hazard  = fw_en ? (w_exe_hit && exe_mem_r_en) : (w_exe_hit || w_mem_hit);
  end

  always_comb begin
    w_freeze_all = 1'b0;
    w_flush      = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        if (!sram_ready && (mem_req || (r_state == ST_MEM_WAIT))) begin
          w_freeze_all = 1'b1;
        end else if (br_taken) begin
          w_flush = 1'b1;
        end else if (w_hazard) begin
          w_stall = 1'b1;
        end
      end
      default: w_freeze_all = 1'b1;
    endcase
  end

  // Reset overrides every pipeline control without waiting for a clock edge.
  always_comb begin
    freeze_pc     = rst & (w_freeze_all | w_stall);
    freeze_if_id  = rst & (w_freeze_all | w_stall);
    flush_if_id   = rst & w_flush;
    bubble_id_ex  = rst & (w_flush | w_stall);
    freeze_id_ex  = rst & w_freeze_all;
    freeze_ex_mem = rst & w_freeze_all;
    mem_timeout   = r_mem_timeout;
    stall_count   = r_stall_count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_timer       <= 8'd0;
      r_mem_timeout <= 1'b0;
      r_stall_count <= '0;
    end else begin
      if (freeze_pc && (r_stall_count != c_cnt_max)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      case (r_state)
        ST_RUN: begin
          if (mem_req && !sram_ready) begin
            r_state <= ST_MEM_WAIT;
            r_timer <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (sram_ready) begin
            r_state <= ST_RUN;
            r_timer <= 8'd0;
          end else if (r_timer == c_wait_max) begin
            r_state       <= ST_TIMEOUT;
            r_mem_timeout <= 1'b1;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        ST_TIMEOUT: r_mem_timeout <= 1'b1;
        default:    r_state       <= ST_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipeline_hazard_ctrl                                         |
// | Brief    : Randomized and directed bench against a behavioural model.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 6;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             fw_en, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic             br_taken, mem_req, sram_ready;
  logic [4:0]       id_src1, id_src2, exe_dest, mem_dest;
  logic             freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex;
  logic             freeze_id_ex, freeze_ex_mem, mem_timeout;
  logic [CNT_W-1:0] stall_count;

  int n_vec = 0;
  int n_err = 0;

  pipeline_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fw_en(fw_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .br_taken(br_taken), .mem_req(mem_req), .sram_ready(sram_ready),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
    .bubble_id_ex(bubble_id_ex), .freeze_id_ex(freeze_id_ex),
    .freeze_ex_mem(freeze_ex_mem), .mem_timeout(mem_timeout),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory-wait bookkeeping as plain counters and flags.
  bit waiting, dead, sticky;
  int waits_seen, stalls;
  bit e_fpc, e_flush, e_bub, e_fall, e_haz, e_hit_x, e_hit_m;

  function automatic bit reads(input logic [4:0] r, input logic [4:0] d, input logic en);
    bit a;
    bit b;
    a = (id_src1 != 0) && en && (id_src1 == d);
    b = id_two_src && (id_src2 != 0) && en && (id_src2 == d);
    reads = a || b || (r == 5'h1f && 1'b0);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      waiting = 0; dead = 0; sticky = 0; waits_seen = 0; stalls = 0;
      check("rst_outs", {freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex,
                         freeze_id_ex, freeze_ex_mem}, 0);
      check("rst_timeout", {31'd0, mem_timeout}, 0);
      check("rst_count", 32'(stall_count), 0);
    end else begin
      e_hit_x = reads(5'd0, exe_dest, exe_wb_en);
      e_hit_m = reads(5'd0, mem_dest, mem_wb_en);
      e_haz   = fw_en ? (e_hit_x && exe_mem_r_en) : (e_hit_x || e_hit_m);
      e_fall  = dead || (!sram_ready && (waiting || mem_req));
      e_flush = !e_fall && br_taken;
      e_fpc   = e_fall || (!e_fall && !br_taken && e_haz);
      e_bub   = e_flush || (e_fpc && !e_fall);
      check("freeze_pc", {31'd0, freeze_pc}, {31'd0, e_fpc});
      check("freeze_if_id", {31'd0, freeze_if_id}, {31'd0, e_fpc});
      check("flush_if_id", {31'd0, flush_if_id}, {31'd0, e_flush});
      check("bubble_id_ex", {31'd0, bubble_id_ex}, {31'd0, e_bub});
      check("freeze_id_ex", {31'd0, freeze_id_ex}, {31'd0, e_fall});
      check("freeze_ex_mem", {31'd0, freeze_ex_mem}, {31'd0, e_fall});
      check("mem_timeout", {31'd0, mem_timeout}, {31'd0, sticky});
      check("stall_count", 32'(stall_count), stalls);
      check("flush_vs_freeze", {31'd0, flush_if_id & freeze_if_id}, 0);
      if (e_fpc && stalls < CNT_MAX) stalls++;
      if (!dead) begin
        if (waiting) begin
          if (sram_ready) begin
            waiting = 0;
            waits_seen = 0;
          end else begin
            waits_seen++;
            if (waits_seen >= WAIT_MAX) begin
              dead = 1;
              sticky = 1;
            end
          end
        end else if (mem_req && !sram_ready) begin
          waiting = 1;
          waits_seen = 0;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fw_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = 0; mem_wb_en = 0; br_taken = 0; mem_req = 0; sram_ready = 1;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    repeat (2) next_cycle();
    rst = 1;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    do_reset();

    // Load-use with forwarding: one stall cycle, released once the load moves on.
    fw_en = 1; exe_dest = 5; exe_wb_en = 1; exe_mem_r_en = 1; id_src1 = 5;
    #1;
    check("t1_stall_pc", {31'd0, freeze_pc}, 1);
    check("t1_stall_bub", {31'd0, bubble_id_ex}, 1);
    check("t1_no_idex_frz", {31'd0, freeze_id_ex}, 0);
    next_cycle();
    exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 5; mem_wb_en = 1;
    #1;
    check("t1_released", {31'd0, freeze_pc}, 0);

    // Second source only matters when the instruction reads it.
    next_cycle();
    idle_inputs();
    mem_dest = 7; mem_wb_en = 1; id_src1 = 1; id_src2 = 7; id_two_src = 0;
    #1;
    check("t2_one_src", {31'd0, freeze_pc}, 0);
    id_two_src = 1;
    #1;
    check("t2_two_src", {31'd0, freeze_pc}, 1);

    next_cycle();
    idle_inputs();
    exe_dest = 0; exe_wb_en = 1;
    #1;
    check("t3_r0", {31'd0, freeze_pc}, 0);

    next_cycle();
    idle_inputs();
    fw_en = 1; exe_dest = 9; exe_wb_en = 1; exe_mem_r_en = 1; id_src1 = 9; br_taken = 1;
    #1;
    check("t4_flush", {31'd0, flush_if_id}, 1);
    check("t4_bubble", {31'd0, bubble_id_ex}, 1);
    check("t4_no_freeze", {31'd0, freeze_pc}, 0);

    // Memory wait: request cycle plus three waits, then ready.
    next_cycle();
    do_reset();
    mem_req = 1; sram_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t5_frozen", {31'd0, freeze_ex_mem}, 1);
      next_cycle();
      mem_req = 0;
    end
    sram_ready = 1;
    #1;
    check("t5_release", {31'd0, freeze_ex_mem}, 0);
    next_cycle();
    #1;
    check("t5_count", 32'(stall_count), 4);

    // Timeout: sticky, frozen, counter saturates, cleared only by reset.
    mem_req = 1; sram_ready = 0;
    next_cycle();
    mem_req = 0;
    repeat (WAIT_MAX) next_cycle();
    #1;
    check("t6_timeout", {31'd0, mem_timeout}, 1);
    repeat (70) next_cycle();
    sram_ready = 1; br_taken = 1;
    #1;
    check("t6_still_frozen", {31'd0, freeze_id_ex}, 1);
    check("t6_saturated", 32'(stall_count), CNT_MAX);
    rst = 0;
    #1;
    check("t6_async_drop", {31'd0, freeze_pc}, 0);
    check("t6_async_clear", {31'd0, mem_timeout}, 0);
    next_cycle();
    rst = 1;
    idle_inputs();

    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rst          = ($urandom_range(0, 59) != 0);
      fw_en        = 1'($urandom_range(0, 1));
      id_src1      = 5'($urandom_range(0, 3));
      id_src2      = 5'($urandom_range(0, 3));
      id_two_src   = 1'($urandom_range(0, 1));
      exe_dest     = 5'($urandom_range(0, 3));
      exe_wb_en    = 1'($urandom_range(0, 1));
      exe_mem_r_en = 1'($urandom_range(0, 1));
      mem_dest     = 5'($urandom_range(0, 3));
      mem_wb_en    = 1'($urandom_range(0, 1));
      br_taken     = ($urandom_range(0, 5) == 0);
      mem_req      = ($urandom_range(0, 4) == 0);
      sram_ready   = 1'($urandom_range(0, 1));
    end
    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
